instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer.sv | 117 +++++++++++
 tb/tb_instruction_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: 16-word program store that steps a processor
// through words 0..end, holding each for its opcode-dependent length.
module instruction_sequencer (
    input  logic        clock,
    input  logic        resetn,
    input  logic        load_en,
    input  logic [3:0]  load_addr,
    input  logic [15:0] load_data,
    input  logic        start,
    input  logic [3:0]  end_addr,
    input  logic        abort,
    output logic [15:0] iin,
    output logic        proc_resetn,
    output logic [3:0]  pc,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  pc_q, pc_d;
    logic [3:0]  end_q, end_d;
    logic [1:0]  cyc_q, cyc_d;
    logic        err_q, err_d;
    logic        illegal;
    logic [1:0]  last_cyc;
    logic [15:0] mem [16];

    // Program store: writable only while idle, never reset.
    always_ff @(posedge clock) begin
        if (load_en && state_q == IDLE) begin
            mem[load_addr] <= load_data;
        end
    end

    // Current word and its decoded length (add/sub 4 cycles, others 2).
    always_comb begin
        iin      = mem[pc_q];
        illegal  = iin[15];
        last_cyc = (!iin[15] && iin[14]) ? 2'd3 : 2'd1;
    end

    // Next-state logic; abort outranks instruction completion.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        end_d   = end_q;
        cyc_d   = cyc_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start && !load_en && !abort) begin
                    state_d = EXEC;
                    pc_d    = 4'd0;
                    cyc_d   = 2'd0;
                    end_d   = end_addr;
                    err_d   = 1'b0;
                end
            end
            EXEC: begin
                err_d = err_q | illegal;
                if (abort) begin
                    state_d = IDLE;
                end else if (cyc_q == last_cyc) begin
                    if (pc_q == end_q) begin
                        state_d = DONE;
                    end else begin
                        pc_d  = pc_q + 4'd1;
                        cyc_d = 2'd0;
                    end
                end else begin
                    cyc_d = cyc_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            pc_q    <= 4'd0;
            end_q   <= 4'd0;
            cyc_q   <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            end_q   <= end_d;
            cyc_q   <= cyc_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from registered state; err shows an illegal
    // word already during its first EXEC cycle.
    always_comb begin
        pc          = pc_q;
        busy        = (state_q == EXEC);
        done        = (state_q == DONE);
        proc_resetn = (state_q != IDLE);
        err         = err_q | ((state_q == EXEC) & illegal);
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: runs are expanded from
// a memory model into per-cycle expectations, popped by a monitor.
module tb_instruction_sequencer;

    logic        clock = 1'b0;
    logic        resetn;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic        start;
    logic [3:0]  end_addr;
    logic        abort;
    logic [15:0] iin;
    logic        proc_resetn;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic        err;

    instruction_sequencer dut (
        .clock       (clock),
        .resetn      (resetn),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .end_addr    (end_addr),
        .abort       (abort),
        .iin         (iin),
        .proc_resetn (proc_resetn),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        dn;
        logic [3:0]  pc;
        logic [15:0] iin;
        logic        er;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [15:0] mem_m [16];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic int len_of(input logic [15:0] w);
        return (w[15:14] == 2'b01) ? 4 : 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
        mem_m[a]  = d;
    endtask

    // Expand a run into expected per-cycle outputs, then drive it.
    task automatic run(input logic [3:0] e, input int abort_at,
                       input bit noise);
        int   total = 0;
        int   k = 0;
        logic er = 1'b0;
        logic fer = 1'b0;
        logic [3:0] fpc = e;
        for (int a = 0; a <= int'(e); a++) total += len_of(mem_m[a]);
        if (abort_at >= total) abort_at = -1;
        for (int a = 0; a <= int'(e); a++) begin
            er = er | mem_m[a][15];
            for (int c = 0; c < len_of(mem_m[a]); c++) begin
                if (abort_at < 0 || k <= abort_at) begin
                    q.push_back('{1'b0, 4'(a), mem_m[a], er});
                    if (k == abort_at) begin
                        fpc = 4'(a);
                        fer = er;
                    end
                end
                k++;
            end
        end
        if (abort_at < 0) begin
            q.push_back('{1'b1, e, mem_m[e], er});
            fer = er;
        end
        start    = 1'b1;
        end_addr = e;
        step();
        start    = 1'b0;
        end_addr = 4'($urandom);
        for (int i = 0; i < total; i++) begin
            if (noise) begin
                load_en   = 1'($urandom);
                load_addr = 4'($urandom);
                load_data = 16'($urandom);
                start     = 1'($urandom);
            end
            if (i == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                break;
            end
            step();
        end
        load_en = 1'b0;
        start   = 1'b0;
        if (abort_at < 0) step();
        @(negedge clock);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_proc_resetn", proc_resetn, 0);
        chk("idle_err", err, fer);
        chk("idle_pc", pc, fpc);
    endtask

    // Monitor: every busy/done cycle must match the next expectation.
    always @(negedge clock) begin
        if (resetn === 1'b1 && (busy === 1'b1 || done === 1'b1)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", {busy, done}, 0);
            end else begin
                mon_e = q.pop_front();
                chk("busy", busy, !mon_e.dn);
                chk("done", done, mon_e.dn);
                chk("pc", pc, mon_e.pc);
                chk("iin", iin, mon_e.iin);
                chk("err", err, mon_e.er);
                chk("proc_resetn", proc_resetn, 1);
            end
        end
    end

    initial begin
        int ab;
        resetn    = 1'b0;
        load_en   = 1'b0;
        load_addr = 4'd0;
        load_data = 16'd0;
        start     = 1'b0;
        end_addr  = 4'd0;
        abort     = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_proc_resetn", proc_resetn, 0);
        chk("rst_err", err, 0);
        chk("rst_pc", pc, 0);
        #20;
        resetn = 1'b1;
        @(negedge clock);
        chk("post_rst_busy", busy, 0);

        // All sixteen words mv: 32 busy cycles, pc 0..15, no wrap.
        for (int a = 0; a < 16; a++) load(4'(a), 16'($urandom) & 16'h1fff);
        run(4'd15, -1, 0);

        // mv then add.
        load(4'd0, 16'h0000);
        load(4'd1, 16'h4000);
        run(4'd1, -1, 0);

        // Illegal word sets sticky err; next start clears it.
        load(4'd0, 16'he000);
        run(4'd0, -1, 0);
        load(4'd0, 16'h2000);
        run(4'd0, -1, 0);

        // Abort in the third cycle of an add.
        load(4'd0, 16'h6000);
        run(4'd0, 2, 0);

        // Start together with abort, or with load, is refused.
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk("start_with_abort", busy, 0);
        load_en   = 1'b1;
        start     = 1'b1;
        load_addr = 4'd3;
        load_data = 16'h3abc;
        step();
        load_en   = 1'b0;
        start     = 1'b0;
        mem_m[3]  = 16'h3abc;
        @(negedge clock);
        chk("start_with_load", busy, 0);
        run(4'd3, -1, 1);

        // Reset mid-run: outputs clear at once, memory survives.
        for (int a = 0; a < 6; a++) load(4'(a), 16'h0100 + 16'(a));
        load(4'd5, 16'h1234);
        q.push_back('{1'b0, 4'd0, mem_m[0], 1'b0});
        q.push_back('{1'b0, 4'd0, mem_m[0], 1'b0});
        q.push_back('{1'b0, 4'd1, mem_m[1], 1'b0});
        start    = 1'b1;
        end_addr = 4'd5;
        step();
        start = 1'b0;
        step();
        step();
        step();
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_proc_resetn", proc_resetn, 0);
        chk("mid_rst_pc", pc, 0);
        chk("mid_rst_iin", iin, mem_m[0]);
        step();
        step();
        resetn = 1'b1;
        @(negedge clock);
        chk("after_rst_busy", busy, 0);
        run(4'd5, -1, 0);

        // Randomized programs, run lengths, aborts and noise.
        for (int n = 0; n < 30; n++) begin
            for (int w = 0; w < int'($urandom_range(0, 4)); w++) begin
                load(4'($urandom), 16'($urandom));
            end
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            run(4'($urandom_range(0, 15)), ab, 1'($urandom));
        end

        step();
        step();
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
